bit_serial_subtractor: RTL and testbench

Multi-cycle, LSB-first bit-serial subtractor computing `a - b` for WIDTH-bit operands. It processes one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart to the ripple full-adder datapath and uses a start/busy/done handshake so the ALU control FSM can issue operations and collect results. Results include unsigned borrow, signed overflow and zero flags.

---
 rtl/bit_serial_subtractor.sv | 104 ++++++++++
 tb/tb_bit_serial_subtractor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: LSB-first serial a-b through one full-subtractor cell, with borrow/overflow/zero flags
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bf_q, bf_d, am_q, am_d, bm_q, bm_d;
  logic borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic x, y, d, nb, last;
  always_comb begin
    x = sa_q[0];
    y = sb_q[0];
    d = x ^ y ^ bf_q;
    nb = (~x & y) | (~(x ^ y) & bf_q);
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    sa_d = sa_q;
    sb_d = sb_q;
    res_d = res_q;
    bf_d = bf_q;
    cnt_d = cnt_q;
    am_d = am_q;
    bm_d = bm_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      sa_d = a;
      sb_d = b;
      res_d = '0;
      bf_d = 1'b0;
      cnt_d = '0;
      am_d = a[WIDTH-1];
      bm_d = b[WIDTH-1];
    end else if (state_q == RUN) begin
      res_d = {d, res_q[WIDTH-1:1]};
      sa_d = sa_q >> 1;
      sb_d = sb_q >> 1;
      bf_d = nb;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        diff_d = res_d;
        borrow_d = nb;
        ovf_d = (am_q ^ bm_q) & (am_q ^ res_d[WIDTH-1]);
        zero_d = res_d == '0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      res_q <= '0;
      bf_q <= 1'b0;
      cnt_q <= '0;
      am_q <= 1'b0;
      bm_q <= 1'b0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      res_q <= res_d;
      bf_q <= bf_d;
      cnt_q <= cnt_d;
      am_q <= am_d;
      bm_q <= bm_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign diff = diff_q;
  assign borrow = borrow_q;
  assign overflow = ovf_q;
  assign zero = zero_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb_bit_serial_subtractor: directed and back-to-back random checks of bit_serial_subtractor at WIDTH 8 and 16
module tb_bit_serial_subtractor;
  logic clk = 1'b0;
  logic rst, start8, start16;
  logic [7:0] a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic borrow8, ovf8, zero8, busy8, done8;
  logic borrow16, ovf16, zero16, busy16, done16;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  bit_serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .diff(diff8),
    .borrow(borrow8), .overflow(ovf8), .zero(zero8), .busy(busy8), .done(done8)
  );
  bit_serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .diff(diff16),
    .borrow(borrow16), .overflow(ovf16), .zero(zero16), .busy(busy16), .done(done16)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start8 = 1'b1;
    start16 = 1'b1;
    a8 = 8'h5A;
    b8 = 8'h23;
    a16 = 16'h1234;
    b16 = 16'h0001;
    tick();
    tick();
    start8 = 1'b0;
    start16 = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if ({diff8, borrow8, ovf8, zero8, busy8, done8} !== 13'h0) begin
      bad++;
      $display("FAIL reset8 got=%h expected=0", {diff8, borrow8, ovf8, zero8, busy8, done8});
    end
    total++;
    if ({diff16, borrow16, ovf16, zero16, busy16, done16} !== 21'h0) begin
      bad++;
      $display("FAIL reset16 got=%h expected=0", {diff16, borrow16, ovf16, zero16, busy16, done16});
    end
  endtask
  task automatic run8(input string nm, input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                      input logic eb, input logic eo, input logic ez);
    int n, nbusy;
    a8 = ta;
    b8 = tb_;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hA5;
    b8 = 8'h3C;
    n = 0;
    nbusy = 0;
    while (!done8 && n < 40) begin
      if (busy8) nbusy++;
      tick();
      n++;
    end
    total++;
    if (n !== 8 || nbusy !== 8) begin
      bad++;
      $display("FAIL %s_timing latency=%0d busy=%0d expected=8/8", nm, n, nbusy);
    end
    total++;
    if (busy8 !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_at_done got=%b expected=0", nm, busy8);
    end
    total++;
    if ({diff8, borrow8, ovf8, zero8} !== {ed, eb, eo, ez}) begin
      bad++;
      $display("FAIL %s got diff=%h b=%b o=%b z=%b expected diff=%h b=%b o=%b z=%b",
               nm, diff8, borrow8, ovf8, zero8, ed, eb, eo, ez);
    end
    tick();
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL %s_after_done done=%b busy=%b expected=0/0", nm, done8, busy8);
    end
  endtask
  task automatic test_vectors;
    run8("v5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
    run8("v10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
    run8("v00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    run8("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run8("v7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_ignore;
    int n, ndone, nbusy;
    a8 = 8'h33;
    b8 = 8'h33;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'h12;
    b8 = 8'h05;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if ({diff8, borrow8, zero8} !== {8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ignore_result got diff=%h b=%b z=%b expected diff=00 b=0 z=1", diff8, borrow8, zero8);
    end
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
      if (busy8) nbusy++;
    end
    total++;
    if (ndone !== 0 || nbusy !== 0) begin
      bad++;
      $display("FAIL ignore_queued extra done=%0d busy=%0d expected=0/0", ndone, nbusy);
    end
  endtask
  task automatic test_reset_mid;
    int ndone;
    a8 = 8'h5A;
    b8 = 8'h23;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({diff8, borrow8, ovf8, zero8, busy8, done8} !== 13'h0) begin
      bad++;
      $display("FAIL reset_mid got=%h expected=0", {diff8, borrow8, ovf8, zero8, busy8, done8});
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL reset_mid_activity got=%0d expected=0", ndone);
    end
    run8("post_rst", 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_back_to_back8;
    logic [7:0] ca, cb, ed;
    int n;
    int sd;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    start8 = 1'b1;
    n = 0;
    while (!busy8 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 1000; i++) begin
      ca = a8;
      cb = b8;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      n = 0;
      while (!done8 && n < 40) begin
        tick();
        n++;
      end
      total++;
      if (n !== 8) begin
        bad++;
        $display("FAIL b2b8_latency op=%0d got=%0d expected=8", i, n);
      end
      ed = ca - cb;
      sd = int'($signed(ca)) - int'($signed(cb));
      total++;
      if ({diff8, borrow8, ovf8, zero8} !== {ed, ca < cb, sd > 127 || sd < -128, ed == 8'h00}) begin
        bad++;
        $display("FAIL b2b8 %h-%h got diff=%h b=%b o=%b z=%b expected diff=%h b=%b o=%b z=%b",
                 ca, cb, diff8, borrow8, ovf8, zero8, ed, ca < cb, sd > 127 || sd < -128, ed == 8'h00);
      end
      n = 0;
      while (!busy8 && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (n !== 2) begin
        bad++;
        $display("FAIL b2b8_gap op=%0d got=%0d expected=2", i, n);
      end
    end
    start8 = 1'b0;
  endtask
  task automatic test_back_to_back16;
    logic [15:0] ca, cb, ed;
    int n;
    int sd;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    start16 = 1'b1;
    n = 0;
    while (!busy16 && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 1000; i++) begin
      ca = a16;
      cb = b16;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      n = 0;
      while (!done16 && n < 60) begin
        tick();
        n++;
      end
      total++;
      if (n !== 16) begin
        bad++;
        $display("FAIL b2b16_latency op=%0d got=%0d expected=16", i, n);
      end
      ed = ca - cb;
      sd = int'($signed(ca)) - int'($signed(cb));
      total++;
      if ({diff16, borrow16, ovf16, zero16} !== {ed, ca < cb, sd > 32767 || sd < -32768, ed == 16'h0000}) begin
        bad++;
        $display("FAIL b2b16 %h-%h got diff=%h b=%b o=%b z=%b expected diff=%h b=%b o=%b z=%b",
                 ca, cb, diff16, borrow16, ovf16, zero16, ed, ca < cb, sd > 32767 || sd < -32768, ed == 16'h0000);
      end
      n = 0;
      while (!busy16 && n < 30) begin
        tick();
        n++;
      end
      total++;
      if (n !== 2) begin
        bad++;
        $display("FAIL b2b16_gap op=%0d got=%0d expected=2", i, n);
      end
    end
    start16 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_ignore();
    test_reset_mid();
    test_back_to_back8();
    test_back_to_back16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
